// File: rtl/regwb_sequencer.sv
// Write-back sequencer for the register-file write port of the
// multicycle MIPS datapath.
//
// Ports:
//   clk, reset     rising-edge clock, async active-high reset
//   wb_req         write-back request (sampled only when idle)
//   wb_src         RegData source code (0000..1000 valid)
//   wb_dst         destination select: rt, rd, $31, $29
//   rt, rd         instruction register fields
//   muldiv_busy    HI/LO not yet valid
//   flush          abort the pending write
//   regdata_sel    RegData mux select
//   reg_dst        register-file write address
//   reg_write      one-cycle register-file write enable
//   wb_busy        sequencer not idle
//   wb_done        one-cycle completion pulse
//   wb_err         one-cycle pulse for an invalid source code
module regwb_sequencer #(
    parameter int MEM_WAIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wb_req,
    input  logic [3:0] wb_src,
    input  logic [1:0] wb_dst,
    input  logic [4:0] rt,
    input  logic [4:0] rd,
    input  logic       muldiv_busy,
    input  logic       flush,
    output logic [3:0] regdata_sel,
    output logic [4:0] reg_dst,
    output logic       reg_write,
    output logic       wb_busy,
    output logic       wb_done,
    output logic       wb_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_WRITE
    } state_t;

    localparam logic [3:0] MEM_WAIT_C = 4'(MEM_WAIT);

    state_t     state_q;
    logic [3:0] cnt_q;
    logic [3:0] src_q;
    logic [4:0] dst_q;
    logic [3:0] sel_q;
    logic [4:0] rdst_q;
    logic       we_q;
    logic       busy_q;
    logic       done_q;
    logic       err_q;

    logic [4:0] dst_d;
    logic [3:0] cnt_d;
    logic       src_hilo;
    logic       src_bad;

    // Destination is resolved from the request, not at write time,
    // so rt/rd may change while the write is pending.
    always_comb begin
        dst_d = 5'd0;
        unique case (wb_dst)
            2'b00:   dst_d = rt;
            2'b01:   dst_d = rd;
            2'b10:   dst_d = 5'd31;
            default: dst_d = 5'd29;
        endcase
    end

    // Memory-derived sources need the read latency to elapse.
    always_comb begin
        cnt_d = 4'd0;
        if (wb_src == 4'b0001 || wb_src == 4'b0110 ||
            wb_src == 4'b0111)
            cnt_d = MEM_WAIT_C;
    end

    assign src_hilo = (src_q == 4'b0011) || (src_q == 4'b0100);
    assign src_bad  = (src_q > 4'b1000);

    // Outputs are computed from the next state, so they appear
    // in the same cycle as the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            src_q   <= 4'd0;
            dst_q   <= 5'd0;
            sel_q   <= 4'd0;
            rdst_q  <= 5'd0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (wb_req) begin
                        state_q <= S_WAIT;
                        src_q   <= wb_src;
                        dst_q   <= dst_d;
                        cnt_q   <= cnt_d;
                        sel_q   <= wb_src;
                        rdst_q  <= dst_d;
                        busy_q  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                        cnt_q   <= 4'd0;
                        sel_q   <= 4'd0;
                        rdst_q  <= 5'd0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else if (!(src_hilo && muldiv_busy)) begin
                        state_q <= S_WRITE;
                        done_q  <= 1'b1;
                        if (src_bad) begin
                            sel_q <= 4'd0;
                            err_q <= 1'b1;
                        end else begin
                            // Writes to $zero complete silently.
                            we_q <= (dst_q != 5'd0);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= 4'd0;
                    sel_q   <= 4'd0;
                    rdst_q  <= 5'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign regdata_sel = sel_q;
    assign reg_dst     = rdst_q;
    assign reg_write   = we_q;
    assign wb_busy     = busy_q;
    assign wb_done     = done_q;
    assign wb_err      = err_q;

endmodule

// File: tb/tb_regwb_sequencer.sv
// Directed bench for regwb_sequencer (MEM_WAIT = 2).
// Vector table plus hand sequences for flush, reset and overlap.
module tb_regwb_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wb_req = 1'b0;
    logic [3:0] wb_src = 4'd0;
    logic [1:0] wb_dst = 2'd0;
    logic [4:0] rt = 5'd0;
    logic [4:0] rd = 5'd0;
    logic       muldiv_busy = 1'b0;
    logic       flush = 1'b0;
    logic [3:0] regdata_sel;
    logic [4:0] reg_dst;
    logic       reg_write;
    logic       wb_busy;
    logic       wb_done;
    logic       wb_err;

    int n_checks = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int write_cnt = 0;
    int err_cnt = 0;
    logic prev_w = 1'b0;

    regwb_sequencer #(.MEM_WAIT(2)) dut (
        .clk(clk),
        .reset(reset),
        .wb_req(wb_req),
        .wb_src(wb_src),
        .wb_dst(wb_dst),
        .rt(rt),
        .rd(rd),
        .muldiv_busy(muldiv_busy),
        .flush(flush),
        .regdata_sel(regdata_sel),
        .reg_dst(reg_dst),
        .reg_write(reg_write),
        .wb_busy(wb_busy),
        .wb_done(wb_done),
        .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] src;
        logic [1:0] dst;
        logic [4:0] rt;
        logic [4:0] rd;
        int         mb;
        int         exp_wait;
        logic [3:0] exp_sel;
        logic [4:0] exp_dst;
        logic       exp_w;
        logic       exp_e;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input int act,
                       input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d",
                     name, act, exp);
        end
    endtask

    // Cycle invariants on the strobes.
    always @(negedge clk) begin
        if (reset) begin
            prev_w = 1'b0;
        end else begin
            chk("w_without_done", int'(reg_write && !wb_done), 0);
            chk("err_without_done", int'(wb_err && !wb_done), 0);
            chk("done_when_idle", int'(wb_done && !wb_busy), 0);
            chk("w_back_to_back", int'(reg_write && prev_w), 0);
            prev_w = reg_write;
            if (wb_done) done_cnt++;
            if (reg_write) write_cnt++;
            if (wb_err) err_cnt++;
        end
    end

    function automatic int idle_bits();
        return int'({wb_busy, regdata_sel, reg_dst,
                     reg_write, wb_done, wb_err});
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        @(negedge clk);
        wb_src = v.src;
        wb_dst = v.dst;
        rt = v.rt;
        rd = v.rd;
        wb_req = 1'b1;
        muldiv_busy = (v.mb > 0);
        @(negedge clk);
        wb_req = 1'b0;
        n = 0;
        while (!wb_done && n < 60) begin
            n++;
            if (n == v.mb) muldiv_busy = 1'b0;
            @(negedge clk);
        end
        muldiv_busy = 1'b0;
        chk($sformatf("v%0d_wait", idx), n, v.exp_wait);
        chk($sformatf("v%0d_done", idx), int'(wb_done), 1);
        chk($sformatf("v%0d_sel", idx), int'(regdata_sel),
            int'(v.exp_sel));
        chk($sformatf("v%0d_dst", idx), int'(reg_dst),
            int'(v.exp_dst));
        chk($sformatf("v%0d_we", idx), int'(reg_write),
            int'(v.exp_w));
        chk($sformatf("v%0d_err", idx), int'(wb_err),
            int'(v.exp_e));
        @(negedge clk);
        chk($sformatf("v%0d_idle", idx), idle_bits(), 0);
    endtask

    initial begin
        int d0;
        int w0;
        int n;
        //          src  dst  rt  rd  mb wait sel  dst  w  e
        vecs[0]  = '{4'h2, 2'd1, 5'd0, 5'd8, 0, 1, 4'h2,
                     5'd8, 1'b1, 1'b0};
        vecs[1]  = '{4'h7, 2'd0, 5'd5, 5'd0, 0, 3, 4'h7,
                     5'd5, 1'b1, 1'b0};
        vecs[2]  = '{4'h3, 2'd1, 5'd0, 5'd12, 6, 6, 4'h3,
                     5'd12, 1'b1, 1'b0};
        vecs[3]  = '{4'h2, 2'd1, 5'd4, 5'd0, 0, 1, 4'h2,
                     5'd0, 1'b0, 1'b0};
        vecs[4]  = '{4'h2, 2'd2, 5'd0, 5'd0, 0, 1, 4'h2,
                     5'd31, 1'b1, 1'b0};
        vecs[5]  = '{4'hB, 2'd1, 5'd0, 5'd9, 0, 1, 4'h0,
                     5'd9, 1'b0, 1'b1};
        vecs[6]  = '{4'h4, 2'd3, 5'd0, 5'd0, 0, 1, 4'h4,
                     5'd29, 1'b1, 1'b0};
        vecs[7]  = '{4'h1, 2'd0, 5'd17, 5'd2, 0, 3, 4'h1,
                     5'd17, 1'b1, 1'b0};
        vecs[8]  = '{4'h6, 2'd1, 5'd1, 5'd3, 0, 3, 4'h6,
                     5'd3, 1'b1, 1'b0};
        vecs[9]  = '{4'h0, 2'd3, 5'd1, 5'd1, 0, 1, 4'h0,
                     5'd29, 1'b1, 1'b0};
        vecs[10] = '{4'h8, 2'd0, 5'd7, 5'd1, 0, 1, 4'h8,
                     5'd7, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        chk("reset_outputs", idle_bits(), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_no_req", idle_bits(), 0);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Second request during WAIT is dropped.
        d0 = done_cnt;
        @(negedge clk);
        wb_src = 4'hB;
        wb_dst = 2'd1;
        rd = 5'd9;
        wb_req = 1'b1;
        @(negedge clk);
        chk("ovl_busy", int'(wb_busy), 1);
        wb_src = 4'h2;
        rd = 5'd8;
        @(negedge clk);
        wb_req = 1'b0;
        chk("ovl_err", int'(wb_err), 1);
        repeat (5) @(negedge clk);
        chk("ovl_one_done", done_cnt - d0, 1);
        chk("ovl_idle", int'(wb_busy), 0);

        // Flush in the 2nd WAIT cycle of a memory write.
        d0 = done_cnt;
        w0 = write_cnt;
        wb_src = 4'h1;
        wb_dst = 2'd0;
        rt = 5'd6;
        wb_req = 1'b1;
        @(negedge clk);
        wb_req = 1'b0;
        chk("fl_wait1", int'(wb_busy), 1);
        @(negedge clk);
        chk("fl_wait2", int'(wb_busy), 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fl_idle", idle_bits(), 0);
        repeat (4) @(negedge clk);
        chk("fl_no_done", done_cnt - d0, 0);
        chk("fl_no_write", write_cnt - w0, 0);

        // Flush in IDLE does not block a request.
        w0 = write_cnt;
        wb_src = 4'h2;
        wb_dst = 2'd1;
        rd = 5'd10;
        wb_req = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        wb_req = 1'b0;
        flush = 1'b0;
        chk("fli_busy", int'(wb_busy), 1);
        chk("fli_dst", int'(reg_dst), 10);
        n = 0;
        while (!wb_done && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("fli_we", int'(reg_write), 1);
        @(negedge clk);
        chk("fli_count", write_cnt - w0, 1);

        // Async reset in the middle of WAIT.
        wb_src = 4'h7;
        wb_dst = 2'd0;
        rt = 5'd5;
        wb_req = 1'b1;
        @(negedge clk);
        wb_req = 1'b0;
        chk("rst_pre_busy", int'(wb_busy), 1);
        chk("rst_pre_sel", int'(regdata_sel), 7);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async", idle_bits(), 0);
        @(negedge clk);
        w0 = write_cnt;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_stays_idle", idle_bits(), 0);
        chk("rst_write_lost", write_cnt - w0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regwb_sequencer.md
Name: regwb_sequencer

Overview:
- Write-back sequencer for the register-file write port of the multicycle MIPS datapath.
- Accepts one write-back request per instruction from the main control unit and latches its source and destination.
- Waits until the selected source is valid: memory read latency, or mult/div completion for HI/LO.
- Drives the 4-bit RegData mux select, the destination register number and a single-cycle RegWrite strobe.

Parameters:
- MEM_WAIT, 2: extra cycles to wait before writing a memory-derived source (MemData/Half/Byte); legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- wb_req  input  1  write-back request; sampled only in IDLE
- wb_src  input  4  RegData source code: 0000 const 227, 0001 MemData, 0010 ALUOut, 0011 HI, 0100 LO, 0101 ShiftReg, 0110 Half, 0111 Byte, 1000 Immediate
- wb_dst  input  2  destination select: 00 rt, 01 rd, 10 $31 (ra), 11 $29 (sp)
- rt  input  5  instruction rt field
- rd  input  5  instruction rd field
- muldiv_busy  input  1  mult/div unit still computing HI/LO
- flush  input  1  synchronous abort of the pending write (exception/cancel)
- regdata_sel  output  4  select to RegData mux
- reg_dst  output  5  register-file write address
- reg_write  output  1  register-file write enable, one cycle per accepted write
- wb_busy  output  1  high whenever state != IDLE
- wb_done  output  1  one-cycle pulse on completion (written, suppressed, or errored)
- wb_err  output  1  one-cycle pulse with wb_done when wb_src > 1000

Behaviour:
- All outputs are registered.
- Asynchronous reset forces state IDLE, cnt = 0, and all outputs to 0.
- States: IDLE, WAIT, WRITE.
- IDLE:
  - On wb_req=1 at an edge, latch src and destination, and load cnt.
  - Destination resolved at latch time: rt, rd, 31 or 29.
  - cnt = MEM_WAIT for src 0001/0110/0111; cnt = 0 otherwise.
  - Next state WAIT.
  - wb_req=0 keeps IDLE.
  - regdata_sel and reg_dst read 0 in IDLE.
- WAIT:
  - regdata_sel = latched src; reg_dst = latched destination.
  - If cnt != 0: cnt decrements each cycle.
  - Leave WAIT when cnt == 0 and, for src 0011/0100, muldiv_busy == 0.
  - Leaving WAIT goes to WRITE; otherwise stay in WAIT with no timeout.
- WRITE (exactly one cycle), then IDLE:
  - regdata_sel and reg_dst held; wb_done=1.
  - reg_write=1 unless reg_dst == 0 (writes to $zero are suppressed: reg_write stays 0, wb_done still pulses).
- Latency from request edge k:
  - Non-memory ready source: WAIT after edge k, WRITE after k+1, IDLE after k+2.
  - Memory source: WRITE after edge k+1+MEM_WAIT.
- Invalid src (1001..1111):
  - Accepted and goes to WAIT with cnt = 0.
  - WRITE cycle asserts wb_done=1 and wb_err=1 with reg_write=0; regdata_sel is driven 0000.
- wb_req while busy: ignored and not queued. The control unit must wait for wb_done.
- flush=1 in WAIT or WRITE: next state IDLE, no reg_write, no wb_done; takes priority over all transitions.
- flush=1 in IDLE: ignored; a wb_req in the same cycle is still accepted.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0; the pending write is lost.
- reg_write, wb_done and wb_err are never high outside WRITE.
- reg_write and wb_done are never high for more than one consecutive cycle.

Test Plan:
1. ALUOut to rd: wb_req with src=0010, dst=01, rd=8 at edge 0 -> sel=0010 and reg_dst=8 from edge 1; reg_write=1 and wb_done=1 only in the cycle after edge 1; IDLE after edge 2.
2. Byte load, MEM_WAIT=2: src=0111, dst=00, rt=5 -> WAIT for 3 cycles; reg_write=1 in the cycle after edge 3; sel=0111, reg_dst=5.
3. HI move: src=0011 with muldiv_busy held high 6 cycles -> stays in WAIT; reg_write asserts the cycle after muldiv_busy falls; sel=0011.
4. Write to $zero and jal: rd=0 -> wb_done=1, reg_write=0. Then src=0010, dst=10 -> reg_dst=31 with reg_write=1.
5. Invalid src=1011 -> wb_done=1, wb_err=1, reg_write=0. A second wb_req issued during WAIT is ignored: exactly one wb_done observed.
6. Disruptions:
   - flush asserted in the 2nd WAIT cycle of a memory write -> IDLE next edge; no reg_write or wb_done.
   - Async reset mid-WAIT -> all outputs 0 immediately, without waiting for a clock edge.
